// File: rtl/pattern_tx.sv
// Bit-serial pattern transmitter: loads a parallel word via load/ready and shifts
// a programmable number of bits out MSB-first, with repetitions and idle gaps.
module pattern_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NB_W  = 4,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic [NB_W-1:0]  nbits_i,
    input  logic [CNT_W-1:0] repeat_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             abort_i,
    output logic             ready_o,
    output logic             d_o,
    output logic             valid_o,
    output logic             done_o
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] word_q, word_nxt;
    logic [NB_W-1:0]  nb_q, nb_nxt;
    logic [NB_W-1:0]  idx_q, idx_nxt;
    logic [CNT_W-1:0] rep_q, rep_nxt;
    logic [GAP_W-1:0] gap_q, gap_nxt;
    logic [GAP_W-1:0] gcnt_q, gcnt_nxt;
    logic             d_nxt, valid_nxt, done_nxt, ready_nxt;
    logic             accept_c;
    logic [NB_W-1:0]  nb_eff_c;
    logic [CNT_W-1:0] rep_init_c;

    // Shift instead of a variable bit-select so the index may be wider than needed.
    function automatic logic bit_of(input logic [WIDTH-1:0] w, input logic [NB_W-1:0] i);
        logic [WIDTH-1:0] sh;
        sh = w >> i;
        return sh[0];
    endfunction

    assign accept_c   = load_i && ready_o && !abort_i;
    assign nb_eff_c   = (nbits_i == '0 || nbits_i > NB_W'(WIDTH)) ? NB_W'(WIDTH) : nbits_i;
    assign rep_init_c = (repeat_i == '0) ? '0 : repeat_i - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            word_q  <= '0;
            nb_q    <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            d_o     <= 1'b0;
            valid_o <= 1'b0;
            done_o  <= 1'b0;
            ready_o <= 1'b1;
        end else begin
            state   <= state_nxt;
            word_q  <= word_nxt;
            nb_q    <= nb_nxt;
            idx_q   <= idx_nxt;
            rep_q   <= rep_nxt;
            gap_q   <= gap_nxt;
            gcnt_q  <= gcnt_nxt;
            d_o     <= d_nxt;
            valid_o <= valid_nxt;
            done_o  <= done_nxt;
            ready_o <= ready_nxt;
        end
    end

    // Next-state and next-output logic; outputs describe the cycle after the edge.
    always_comb begin
        state_nxt = state;
        word_nxt  = word_q;
        nb_nxt    = nb_q;
        idx_nxt   = idx_q;
        rep_nxt   = rep_q;
        gap_nxt   = gap_q;
        gcnt_nxt  = gcnt_q;
        d_nxt     = 1'b0;
        valid_nxt = 1'b0;
        done_nxt  = 1'b0;
        ready_nxt = 1'b0;

        case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                if (accept_c) begin
                    word_nxt  = word_i;
                    nb_nxt    = nb_eff_c;
                    idx_nxt   = nb_eff_c - NB_W'(1);
                    rep_nxt   = rep_init_c;
                    gap_nxt   = gap_i;
                    d_nxt     = bit_of(word_i, nb_eff_c - NB_W'(1));
                    valid_nxt = 1'b1;
                    ready_nxt = 1'b0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (abort_i) begin
                    state_nxt = IDLE;
                    ready_nxt = 1'b1;
                end else if (idx_q != '0) begin
                    idx_nxt   = idx_q - NB_W'(1);
                    d_nxt     = bit_of(word_q, idx_q - NB_W'(1));
                    valid_nxt = 1'b1;
                end else if (rep_q != '0) begin
                    rep_nxt = rep_q - CNT_W'(1);
                    if (gap_q == '0) begin
                        idx_nxt   = nb_q - NB_W'(1);
                        d_nxt     = bit_of(word_q, nb_q - NB_W'(1));
                        valid_nxt = 1'b1;
                    end else begin
                        gcnt_nxt  = gap_q - GAP_W'(1);
                        state_nxt = GAP;
                    end
                end else begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    ready_nxt = 1'b1;
                end
            end
            GAP: begin
                if (abort_i) begin
                    state_nxt = IDLE;
                    ready_nxt = 1'b1;
                end else if (gcnt_q == '0) begin
                    idx_nxt   = nb_q - NB_W'(1);
                    d_nxt     = bit_of(word_q, nb_q - NB_W'(1));
                    valid_nxt = 1'b1;
                    state_nxt = SEND;
                end else begin
                    gcnt_nxt = gcnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_pattern_tx.sv
// Directed self-checking bench for pattern_tx, plus a loopback into a 1011 Moore detector.
module tb_pattern_tx;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NB_W  = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned GAP_W = 4;
    localparam int unsigned NWORDS = 540;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_i;
    logic [WIDTH-1:0] word_i;
    logic [NB_W-1:0]  nbits_i;
    logic [CNT_W-1:0] repeat_i;
    logic [GAP_W-1:0] gap_i;
    logic             abort_i;
    logic             ready_o, d_o, valid_o, done_o;

    int n_cmp = 0;
    int n_bad = 0;

    pattern_tx #(.WIDTH(WIDTH), .NB_W(NB_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .rst(rst), .load_i(load_i), .word_i(word_i), .nbits_i(nbits_i),
        .repeat_i(repeat_i), .gap_i(gap_i), .abort_i(abort_i),
        .ready_o(ready_o), .d_o(d_o), .valid_o(valid_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Moore detector for overlapping 1011, advanced only on valid bits.
    logic       det_clr = 1'b1;
    logic [2:0] det_state;
    logic [2:0] det_nxt;
    int         det_hits;
    int         det_bits;

    always_comb begin
        det_nxt = 3'd0;
        case (det_state)
            3'd0: det_nxt = d_o ? 3'd1 : 3'd0;
            3'd1: det_nxt = d_o ? 3'd1 : 3'd2;
            3'd2: det_nxt = d_o ? 3'd3 : 3'd0;
            3'd3: det_nxt = d_o ? 3'd4 : 3'd2;
            3'd4: det_nxt = d_o ? 3'd1 : 3'd2;
            default: det_nxt = 3'd0;
        endcase
    end

    always @(posedge clk) begin
        if (det_clr) begin
            det_state <= 3'd0;
            det_hits  <= 0;
            det_bits  <= 0;
        end else if (valid_o) begin
            det_state <= det_nxt;
            det_bits  <= det_bits + 1;
            if (det_nxt == 3'd4) det_hits <= det_hits + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one load; afterwards scramble the command inputs to show they were captured.
    task automatic start(input logic [WIDTH-1:0] w, input logic [NB_W-1:0] nb,
                         input logic [CNT_W-1:0] rep, input logic [GAP_W-1:0] gap);
        word_i   = w;
        nbits_i  = nb;
        repeat_i = rep;
        gap_i    = gap;
        load_i   = 1'b1;
        tick();
        load_i   = 1'b0;
        word_i   = ~w;
        nbits_i  = NB_W'(1);
        repeat_i = CNT_W'(7);
        gap_i    = GAP_W'(5);
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        rst = 1'b1; load_i = 1'b1; word_i = 8'hFF; nbits_i = 4'd4;
        repeat_i = 8'd1; gap_i = 4'd0; abort_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            obs = {ready_o, valid_o, d_o, done_o};
            n_cmp++;
            if (obs !== 4'b1000) begin
                n_bad++;
                $display("FAIL reset_hold c%0d: got rdy/val/d/done=%b want 1000", c, obs);
            end
        end
        rst = 1'b0; load_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            obs = {ready_o, valid_o, d_o, done_o};
            n_cmp++;
            if (obs !== 4'b1000) begin
                n_bad++;
                $display("FAIL reset_after c%0d: got rdy/val/d/done=%b want 1000", c, obs);
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] bits;
        logic [3:0] obs;
        bits = 4'b1011;
        start(8'h0B, 4'd4, 8'd1, 4'd0);
        for (int k = 0; k < 4; k++) begin
            obs = {ready_o, valid_o, d_o, done_o};
            n_cmp++;
            if (obs !== {1'b0, 1'b1, bits[3-k], 1'b0}) begin
                n_bad++;
                $display("FAIL single_bit%0d: got rdy/val/d/done=%b want 01%b0", k + 1, obs, bits[3-k]);
            end
            tick();
        end
        obs = {ready_o, valid_o, d_o, done_o};
        n_cmp++;
        if (obs !== 4'b1001) begin
            n_bad++;
            $display("FAIL single_done: got rdy/val/d/done=%b want 1001", obs);
        end
        tick();
        n_cmp++;
        if (done_o !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done_width: got done=%b want 0", done_o);
        end
    endtask

    task automatic test_repeat_gap();
        logic [13:0] exp_v;
        logic [13:0] exp_d;
        logic [3:0]  obs;
        logic [3:0]  want;
        int          nvalid;
        exp_v  = 14'b11100111001110;
        exp_d  = 14'b11000110001100;
        nvalid = 0;
        start(8'b110, 4'd3, 8'd3, 4'd2);
        for (int k = 0; k < 14; k++) begin
            obs  = {ready_o, valid_o, d_o, done_o};
            want = {k == 13, exp_v[13-k], exp_d[13-k], k == 13};
            if (valid_o === 1'b1) nvalid++;
            n_cmp++;
            if (obs !== want) begin
                n_bad++;
                $display("FAIL repgap_cycle%0d: got rdy/val/d/done=%b want %b", k + 1, obs, want);
            end
            if (k < 13) tick();
        end
        n_cmp++;
        if (nvalid != 9) begin
            n_bad++;
            $display("FAIL repgap_valid_count: got %0d want 9", nvalid);
        end
    endtask

    task automatic test_defaults();
        logic [7:0] bits;
        logic [3:0] obs;
        logic [3:0] nbv [2];
        bits = 8'hA5;
        nbv[0] = 4'd0;
        nbv[1] = 4'd15;
        tick();
        for (int r = 0; r < 2; r++) begin
            start(8'hA5, nbv[r], 8'd0, 4'd0);
            for (int k = 0; k < 8; k++) begin
                obs = {ready_o, valid_o, d_o, done_o};
                n_cmp++;
                if (obs !== {1'b0, 1'b1, bits[7-k], 1'b0}) begin
                    n_bad++;
                    $display("FAIL defaults_nb%0d_bit%0d: got %b want 01%b0", nbv[r], k + 1, obs, bits[7-k]);
                end
                tick();
            end
            obs = {ready_o, valid_o, d_o, done_o};
            n_cmp++;
            if (obs !== 4'b1001) begin
                n_bad++;
                $display("FAIL defaults_nb%0d_done: got %b want 1001", nbv[r], obs);
            end
            tick();
        end
    endtask

    task automatic test_abort();
        logic [3:0] obs;
        start(8'hA5, 4'd0, 8'd4, 4'd3);
        for (int k = 1; k < 21; k++) tick();
        n_cmp++;
        if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_in_gap: got val=%b rdy=%b want 0 0", valid_o, ready_o);
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            obs = {ready_o, valid_o, d_o, done_o};
            n_cmp++;
            if (obs !== 4'b1000) begin
                n_bad++;
                $display("FAIL abort_idle c%0d: got rdy/val/d/done=%b want 1000", c, obs);
            end
            tick();
        end
        // abort in IDLE blocks a simultaneous load
        word_i = 8'hFF; nbits_i = 4'd2; repeat_i = 8'd1; gap_i = 4'd0;
        abort_i = 1'b1; load_i = 1'b1;
        tick();
        abort_i = 1'b0; load_i = 1'b0;
        obs = {ready_o, valid_o, d_o, done_o};
        n_cmp++;
        if (obs !== 4'b1000) begin
            n_bad++;
            $display("FAIL abort_blocks_load: got %b want 1000", obs);
        end
        start(8'b10, 4'd2, 8'd1, 4'd0);
        obs = {ready_o, valid_o, d_o, done_o};
        n_cmp++;
        if (obs !== 4'b0110) begin
            n_bad++;
            $display("FAIL post_abort_bit1: got %b want 0110", obs);
        end
        tick();
        obs = {ready_o, valid_o, d_o, done_o};
        n_cmp++;
        if (obs !== 4'b0100) begin
            n_bad++;
            $display("FAIL post_abort_bit2: got %b want 0100", obs);
        end
        tick();
        obs = {ready_o, valid_o, d_o, done_o};
        n_cmp++;
        if (obs !== 4'b1001) begin
            n_bad++;
            $display("FAIL post_abort_done: got %b want 1001", obs);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs;
        start(8'h0B, 4'd4, 8'd1, 4'd0);
        for (int k = 1; k < 4; k++) tick();
        obs = {ready_o, valid_o, d_o, done_o};
        n_cmp++;
        if (obs !== 4'b0110) begin
            n_bad++;
            $display("FAIL b2b_last_old: got %b want 0110", obs);
        end
        tick();
        obs = {ready_o, valid_o, d_o, done_o};
        n_cmp++;
        if (obs !== 4'b1001) begin
            n_bad++;
            $display("FAIL b2b_done1: got %b want 1001", obs);
        end
        start(8'b01, 4'd2, 8'd1, 4'd0);
        obs = {ready_o, valid_o, d_o, done_o};
        n_cmp++;
        if (obs !== 4'b0100) begin
            n_bad++;
            $display("FAIL b2b_new_bit1: got %b want 0100", obs);
        end
        tick();
        obs = {ready_o, valid_o, d_o, done_o};
        n_cmp++;
        if (obs !== 4'b0110) begin
            n_bad++;
            $display("FAIL b2b_new_bit2: got %b want 0110", obs);
        end
        tick();
        obs = {ready_o, valid_o, d_o, done_o};
        n_cmp++;
        if (obs !== 4'b1001) begin
            n_bad++;
            $display("FAIL b2b_done2: got %b want 1001", obs);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [3:0] obs;
        int         ndone;
        ndone = 0;
        start(8'hA5, 4'd0, 8'd2, 4'd1);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        obs = {ready_o, valid_o, d_o, done_o};
        n_cmp++;
        if (obs !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_mid: got %b want 1000", obs);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            if (valid_o !== 1'b0 || done_o !== 1'b0) ndone++;
        end
        n_cmp++;
        if (ndone != 0) begin
            n_bad++;
            $display("FAIL reset_mid_quiet: got %0d active cycles want 0", ndone);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] words [NWORDS];
        bit         stream [$];
        int         golden;
        logic [3:0] win;
        bit         timed_out;
        void'($urandom(123456));
        for (int i = 0; i < NWORDS; i++) begin
            words[i] = 8'($urandom_range(0, 255));
            for (int b = 7; b >= 0; b--) stream.push_back(words[i][b]);
        end
        golden = 0;
        win = 4'b0000;
        for (int i = 0; i < stream.size(); i++) begin
            win = {win[2:0], stream[i]};
            if (i >= 3 && win == 4'b1011) golden++;
        end
        det_clr = 1'b1;
        tick();
        det_clr = 1'b0;
        timed_out = 1'b0;
        for (int i = 0; i < NWORDS && !timed_out; i++) begin
            for (int t = 0; t < 20 && ready_o !== 1'b1; t++) tick();
            if (ready_o !== 1'b1) begin
                timed_out = 1'b1;
            end else begin
                start(words[i], 4'd8, 8'd1, 4'd0);
                for (int t = 0; t < 20 && done_o !== 1'b1; t++) tick();
                if (done_o !== 1'b1) timed_out = 1'b1;
            end
        end
        n_cmp++;
        if (timed_out) begin
            n_bad++;
            $display("FAIL loopback_timeout: got timeout=1 want 0");
        end
        n_cmp++;
        if (det_bits != NWORDS * 8) begin
            n_bad++;
            $display("FAIL loopback_bits: got %0d want %0d", det_bits, NWORDS * 8);
        end
        n_cmp++;
        if (det_hits != golden) begin
            n_bad++;
            $display("FAIL loopback_hits: got %0d want %0d", det_hits, golden);
        end
    endtask

    initial begin
        rst = 1'b1; load_i = 1'b0; abort_i = 1'b0;
        word_i = '0; nbits_i = '0; repeat_i = '0; gap_i = '0;
        test_reset();
        test_single();
        test_repeat_gap();
        test_defaults();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
